muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer that executes the RV32M multiply/divide operations by time-sharing the core's single 32-bit ALU. It accepts one operation at a time from the decode/execute stage and borrows the ALU for 32 iteration cycles. For multiplies it issues one add per cycle, and for divides one subtract per cycle. It then sign-corrects the result and returns the selected 32-bit word with a one-cycle done pulse. It sits beside the ALU in the execute stage; the execute mux gives it the ALU whenever `aluOwn` is high.

## Interface
- No parameters; all datapaths are fixed at 32 bits.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opA`  in  32  rs1 value; captured on an accepted start.
- `opB`  in  32  rs2 value; captured on an accepted start.
- `busy`  out  1  high from the cycle after an accepted start until done is asserted.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  32  final word; held until the next accepted start or reset.
- `aluOwn`  out  1  high in ITER; the execute mux routes the outputs below to the ALU.
- `aluSel`  out  4  ALU opcode: 0000 add, 1100 sub.
- `aluSrcA`  out  32  ALU operand A.
- `aluSrcB`  out  32  ALU operand B.
- `aluResult`  in  32  ALU output, combinational within the same cycle.

## Operation
- States: IDLE, ITER, FIX, DONE.
- **IDLE**
  - On `start`, capture `funct3` and operands.
  - Signed ops (MULH, DIV, REM; MULHSU operand A only) take the magnitude of negative operands. Record `negRes`:
    - MUL/MULH: sign A xor sign B.
    - MULHSU: sign A.
    - DIV: sign A xor sign B.
    - REM: sign A.
  - MUL is treated as unsigned; the low word is identical either way.
- **Shortcuts (IDLE straight to DONE)**
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = `opA`.
  - DIV/REM with `opA`=0x80000000 and `opB`=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **ITER, multiply** (32 cycles, counter 0..31)
  - Registers: `hi`=0, `lo`=|B|.
  - Drive `aluSel`=0000, `aluSrcA`=`hi`, `aluSrcB`=|A|.
  - If `lo[0]`: `sum`=`aluResult`; `carry` = (`sum` < `hi`, unsigned, internal comparator).
  - Otherwise: `sum`=`hi`; `carry`=0.
  - Update `{hi,lo}` = `{carry,sum,lo} >> 1`.
- **ITER, divide** (32 cycles)
  - Registers: `rem`=0, `quo`=|A|.
  - Each cycle:
    - `{msb,rem,quo}` = `{rem,quo} << 1`, computed combinationally.
    - Drive `aluSel`=1100, `aluSrcA`=shifted `rem`, `aluSrcB`=|B|.
    - If `msb` or shifted `rem` ≥ |B| (unsigned): `rem`=`aluResult` and `quo[0]`=1.
    - Otherwise: `rem` = shifted `rem`.
- **FIX** (1 cycle)
  - Multiplies: if `negRes`, apply 64-bit two's complement to `{hi,lo}` internally.
  - Divides: negate the quotient if `negRes` (DIV); negate the remainder if `negRes` (REM).
  - Select the output word: MUL = `lo`; MULH/MULHSU/MULHU = `hi`; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the selected word into `result`.
- **DONE** (1 cycle): `done`=1; next state is IDLE.
- `start` while not in IDLE is ignored, with no queuing.
- Outside ITER: `aluOwn`=0, `aluSel`=0000, `aluSrcA`=0, `aluSrcB`=0.

## Timing
- Reset, and reset mid-operation: return to IDLE on the next edge. Output values after reset:
  - `busy`=0, `done`=0, `result`=0, `aluOwn`=0.
  - `aluSel`=0000, `aluSrcA`=0, `aluSrcB`=0.
  - Iteration counter = 0.
- A borrowed ALU cycle is abandoned with no side effects.
- Normal op, with start sampled at edge 0:
  - ITER covers cycles 1–32, with `aluOwn`=1.
  - FIX is cycle 33.
  - `done` is high in cycle 34, i.e. 34-cycle latency.
- Shortcut op: `done` is high in cycle 1; `aluOwn` never rises.
- `busy` is high in cycles 1..33 (normal op) and low in the done cycle.
  - A new `start` is accepted in the done cycle only if the FSM is already in IDLE; it is not, so the earliest back-to-back start is the cycle after `done`.
- The ALU path is combinational within one cycle: `aluSrcA`/`aluSrcB` → `aluResult` → iteration registers.
- `result` holds its value until the next accepted start. It is not cleared at start, only at reset.

## Test plan
- **MUL:** `opA`=7, `opB`=6 → `done` in cycle 34, `result`=42; `aluOwn` high exactly in cycles 1–32; `busy` low in cycle 34.
- **MULHU and MULH:**
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → `result`=0xFFFFFFFE.
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:**
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU 0xFFFFFFF9 / 2 → 1.
- **Shortcuts:**
  - DIVU 5/0 → 0xFFFFFFFF in cycle 1.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, with `aluOwn` never high.
- **Reset and busy handling:**
  - Assert `rst` in cycle 10 of a MUL → next cycle `busy`=0, `aluOwn`=0, `result`=0; no `done` pulse follows.
  - `start` held high in cycles 1–40 → the second op is accepted at cycle 35, i.e. one op per 35 cycles.
- **Random cross-check:** 1000 random `funct3`/operand pairs, with the ALU instantiated in the bench, compared against a reference model → zero mismatches.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: executes RV32M multiply/divide by borrowing the shared
// 32-bit ALU for 32 shift-add / shift-subtract iterations, then sign-fixing
// the result and returning the selected word with a one-cycle done pulse.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        aluOwn,
    output logic [3:0]  aluSel,
    output logic [31:0] aluSrcA,
    output logic [31:0] aluSrcB,
    input  logic [31:0] aluResult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1100;

    // Registered state. For multiplies {hi,lo} is the product accumulator and
    // opnd holds |A|; for divides hi is the remainder, lo the quotient and
    // opnd holds |B|.
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] result_q, result_d;

    // Operand decode for an incoming request.
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        neg_res;
    logic        div_zero;
    logic        div_ovf;
    logic        shortcut;
    logic [31:0] short_res;
    logic        accept;

    // Iteration datapath.
    logic [31:0] mul_sum;
    logic        mul_carry;
    logic [31:0] rem_sh;
    logic [31:0] quo_sh;
    logic        div_take;

    // Final correction.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_word;

    // Register update; reset returns every flop to its idle value.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    // Request decode: magnitudes, result sign and the two divide shortcuts.
    always_comb begin
        is_div   = funct3[2];
        neg_a    = opA[31] && (funct3 == F_MULH || funct3 == F_MULHSU ||
                               funct3 == F_DIV  || funct3 == F_REM);
        neg_b    = opB[31] && (funct3 == F_MULH || funct3 == F_DIV ||
                               funct3 == F_REM);
        abs_a    = neg_a ? (32'd0 - opA) : opA;
        abs_b    = neg_b ? (32'd0 - opB) : opB;
        case (funct3)
            F_MULH, F_DIV:   neg_res = neg_a ^ neg_b;
            F_MULHSU, F_REM: neg_res = neg_a;
            default:         neg_res = 1'b0;
        endcase
        div_zero = is_div && (opB == 32'd0);
        div_ovf  = (funct3 == F_DIV || funct3 == F_REM) &&
                   (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
        shortcut = div_zero || div_ovf;
        // funct3[1] separates remainder ops from quotient ops among divides.
        if (div_zero) begin
            short_res = funct3[1] ? opA : 32'hFFFF_FFFF;
        end else begin
            short_res = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
        accept   = (state_q == S_IDLE) && start;
    end

    // One iteration step of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = lo_q[0] ? aluResult : hi_q;
        mul_carry = lo_q[0] && (aluResult < hi_q);
        rem_sh    = {hi_q[30:0], lo_q[31]};
        quo_sh    = {lo_q[30:0], 1'b0};
        div_take  = hi_q[31] || (rem_sh >= opnd_q);
    end

    // Sign correction and output word selection used in FIX.
    always_comb begin
        prod_fix = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
        quo_fix  = neg_q ? (32'd0 - lo_q) : lo_q;
        rem_fix  = neg_q ? (32'd0 - hi_q) : hi_q;
        case (op_q)
            F_MUL:                     fix_word = prod_fix[31:0];
            F_MULH, F_MULHSU, F_MULHU: fix_word = prod_fix[63:32];
            F_DIV, F_DIVU:             fix_word = quo_fix;
            default:                   fix_word = rem_fix;
        endcase
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = shortcut ? S_DONE : S_ITER;
            S_ITER: if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath register next values.
    always_comb begin
        // NOTE: every target gets a hold default first so no latch is inferred.
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        if (accept) begin
            op_d  = funct3;
            neg_d = neg_res;
            cnt_d = '0;
            hi_d  = '0;
            if (shortcut) begin
                result_d = short_res;
            end else if (is_div) begin
                lo_d   = abs_a;
                opnd_d = abs_b;
            end else begin
                lo_d   = abs_b;
                opnd_d = abs_a;
            end
        end else if (state_q == S_ITER) begin
            cnt_d = cnt_q + 5'd1;
            if (op_q[2]) begin
                hi_d = div_take ? aluResult : rem_sh;
                lo_d = {quo_sh[31:1], div_take};
            end else begin
                hi_d = {mul_carry, mul_sum[31:1]};
                lo_d = {mul_sum[0], lo_q[31:1]};
            end
        end else if (state_q == S_FIX) begin
            result_d = fix_word;
        end
    end

    // Outputs: status flags and the ALU borrow, driven only while iterating.
    always_comb begin
        busy    = (state_q == S_ITER) || (state_q == S_FIX);
        done    = (state_q == S_DONE);
        result  = result_q;
        aluOwn  = (state_q == S_ITER);
        aluSel  = ALU_ADD;
        aluSrcA = '0;
        aluSrcB = '0;
        if (state_q == S_ITER) begin
            aluSel  = op_q[2] ? ALU_SUB : ALU_ADD;
            aluSrcA = op_q[2] ? rem_sh : hi_q;
            aluSrcB = opnd_q;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomised bench for muldiv_sequencer with a simple add/sub
// ALU standing in for the core's execute-stage ALU.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        aluOwn;
    logic [3:0]  aluSel;
    logic [31:0] aluSrcA;
    logic [31:0] aluSrcB;
    logic [31:0] aluResult;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .aluOwn    (aluOwn),
        .aluSel    (aluSel),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .aluResult (aluResult)
    );

    // Stand-in execute ALU: add, or subtract for opcode 1100.
    assign aluResult = (aluSel == 4'b1100) ? (aluSrcA - aluSrcB) : (aluSrcA + aluSrcB);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural reference for RV32M.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'b001: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; return p[63:32]; end
            3'b010: begin ea = {{32{a[31]}}, a}; eb = {32'd0, b}; p = ea * eb; return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Launch one op and watch it to completion; exp_lat 34 means a full
    // iterative op, 1 means a shortcut.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, first_own, last_own, busy_cnt;
        start = 1'b1; funct3 = f; opA = a; opB = b;
        tick();
        start = 1'b0;
        lat = 1; first_own = 0; last_own = 0; busy_cnt = 0;
        if (exp_lat == 34) check({tag, "_alusel"}, {28'd0, aluSel}, f[2] ? 32'hC : 32'h0);
        while (!done && lat < 100) begin
            if (aluOwn) begin
                if (first_own == 0) first_own = lat;
                last_own = lat;
            end
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, "_own_first"}, first_own, (exp_lat == 34) ? 1 : 0);
        check({tag, "_own_last"}, last_own, (exp_lat == 34) ? 32 : 0);
        tick();
    endtask

    initial begin
        int done_seen;
        int done1, done2;
        logic [31:0] res1, res2;
        logic [2:0] rf;
        logic [31:0] ra, rb;
        int lat;

        rst = 1'b1; start = 1'b0; funct3 = '0; opA = '0; opB = '0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_aluown", {31'd0, aluOwn}, 32'd0);
        check("rst_alusel", {28'd0, aluSel}, 32'd0);
        check("rst_srca", aluSrcA, 32'd0);
        check("rst_srcb", aluSrcB, 32'd0);
        rst = 1'b0;
        tick();

        run_op("mul_7x6",       3'b000, 32'd7,          32'd6,          32'd42,          34);
        run_op("mulhu_ff",      3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,   34);
        run_op("mulh_ff",       3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,   34);
        run_op("mulhsu_ff",     3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,   34);
        run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   34);
        run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   34);
        run_op("divu_big_2",    3'b101, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,   34);
        run_op("remu_big_2",    3'b111, 32'hFFFF_FFF9,  32'd2,          32'd1,           34);
        run_op("divu_by0",      3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,   1);
        run_op("rem_by0",       3'b110, 32'd5,          32'd0,          32'd5,           1);
        run_op("div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1);
        run_op("rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           1);
        run_op("mul_neg",       3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,   34);
        run_op("div_neg_neg",   3'b100, 32'hFFFF_FFEC,  32'hFFFF_FFFB,  32'd4,           34);

        // Reset in cycle 10 of a MUL: outputs clear, no done follows.
        start = 1'b1; funct3 = 3'b000; opA = 32'd9; opB = 32'd9;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_aluown", {31'd0, aluOwn}, 32'd0);
        check("midrst_result", result, 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);

        // start held high in cycles 0..40; operands change mid-op.
        done1 = 0; done2 = 0; res1 = '0; res2 = '0;
        start = 1'b1; funct3 = 3'b000; opA = 32'd3; opB = 32'd5;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (done) begin
                if (done1 == 0) begin done1 = c; res1 = result; end
                else if (done2 == 0) begin done2 = c; res2 = result; end
            end
            if (c == 35) check("b2b_busy_c35", {31'd0, busy}, 32'd0);
            if (c == 36) check("b2b_busy_c36", {31'd0, busy}, 32'd1);
            if (c == 20) opA = 32'd4;
            if (c == 40) start = 1'b0;
        end
        check("b2b_done1_cycle", done1, 34);
        check("b2b_result1", res1, 32'd15);
        check("b2b_done2_cycle", done2, 69);
        check("b2b_result2", res2, 32'd20);

        // Random cross-check against the reference model.
        for (int i = 0; i < 1000; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            start = 1'b1; funct3 = rf; opA = ra; opB = rb;
            tick();
            start = 1'b0;
            lat = 1;
            while (!done && lat < 100) begin
                tick();
                lat++;
            end
            if (!done) check("rand_timeout", 32'(lat), 32'd34);
            check("rand_result", result, ref_model(rf, ra, rb));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
